// File: rtl/shop_pkg.sv
// Shared encodings and defaults for the shop command path and item database.
package shop_pkg;

    localparam int unsigned DEF_NAME_BITS  = 24;
    localparam int unsigned DEF_STOCK_BITS = 8;

    // Admin username the command FSM compares against when setting is_admin.
    localparam logic [DEF_NAME_BITS-1:0] ADMIN_NAME = "Adm";

    typedef enum logic [1:0] {
        OP_ADD   = 2'd0,
        OP_DEL   = 2'd1,
        OP_BUY   = 2'd2,
        OP_QUERY = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        RSP_OK        = 3'd0,
        RSP_NOT_FOUND = 3'd1,
        RSP_NO_STOCK  = 3'd2,
        RSP_TBL_FULL  = 3'd3,
        RSP_NO_PERM   = 3'd4
    } rsp_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_RESP   = 2'd3
    } db_state_e;

endpackage

// File: rtl/item_table_store.sv
// Item table register array: one combinational read port, one synchronous write port.
module item_table_store #(
    parameter int unsigned NAME_BITS  = 24,
    parameter int unsigned STOCK_BITS = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned IDX_BITS   = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [IDX_BITS-1:0]   i_rd_idx,
    output logic                  o_rd_valid_c,
    output logic [NAME_BITS-1:0]  o_rd_name_c,
    output logic [STOCK_BITS-1:0] o_rd_stock_c,
    input  logic                  i_wr_en,
    input  logic [IDX_BITS-1:0]   i_wr_idx,
    input  logic                  i_wr_valid,
    input  logic [NAME_BITS-1:0]  i_wr_name,
    input  logic [STOCK_BITS-1:0] i_wr_stock
);

    logic [DEPTH-1:0]      valid_q;
    logic [NAME_BITS-1:0]  name_q  [DEPTH];
    logic [STOCK_BITS-1:0] stock_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                name_q[i]  <= '0;
                stock_q[i] <= '0;
            end
        end else if (i_wr_en) begin
            valid_q[i_wr_idx] <= i_wr_valid;
            name_q[i_wr_idx]  <= i_wr_name;
            stock_q[i_wr_idx] <= i_wr_stock;
        end
    end

    assign o_rd_valid_c = valid_q[i_rd_idx];
    assign o_rd_name_c  = name_q[i_rd_idx];
    assign o_rd_stock_c = stock_q[i_rd_idx];

endmodule

// File: rtl/item_db_ctrl.sv
// Item database sequencer: accepts one request, scans the table linearly, applies
// the update in a single cycle and holds the response until it is consumed.
module item_db_ctrl
    import shop_pkg::*;
#(
    parameter int unsigned NAME_BITS  = DEF_NAME_BITS,
    parameter int unsigned STOCK_BITS = DEF_STOCK_BITS,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned IDX_BITS   = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [1:0]            i_req_op,
    input  logic [NAME_BITS-1:0]  i_req_name,
    input  logic [STOCK_BITS-1:0] i_req_qty,
    input  logic                  i_req_is_admin,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [2:0]            o_rsp_code,
    output logic [STOCK_BITS-1:0] o_rsp_stock,
    output logic                  o_busy
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(DEPTH - 1);

    db_state_e             state;
    op_e                   lat_op;
    logic [NAME_BITS-1:0]  lat_name;
    logic [STOCK_BITS-1:0] lat_qty;
    logic [IDX_BITS-1:0]   scan_idx;
    logic                  found;
    logic [IDX_BITS-1:0]   hit_idx;
    logic [STOCK_BITS-1:0] hit_stock;
    logic                  free_found;
    logic [IDX_BITS-1:0]   free_idx;

    logic                  rd_valid_c;
    logic [NAME_BITS-1:0]  rd_name_c;
    logic [STOCK_BITS-1:0] rd_stock_c;
    logic                  match_c;

    logic                  wr_en_c;
    logic [IDX_BITS-1:0]   wr_idx_c;
    logic                  wr_valid_c;
    logic [NAME_BITS-1:0]  wr_name_c;
    logic [STOCK_BITS-1:0] wr_stock_c;
    rsp_e                  upd_code_c;
    logic [STOCK_BITS-1:0] upd_stock_c;
    logic [STOCK_BITS:0]   sat_sum_c;

    item_table_store #(
        .NAME_BITS (NAME_BITS),
        .STOCK_BITS(STOCK_BITS),
        .DEPTH     (DEPTH),
        .IDX_BITS  (IDX_BITS)
    ) u_store (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_rd_idx    (scan_idx),
        .o_rd_valid_c(rd_valid_c),
        .o_rd_name_c (rd_name_c),
        .o_rd_stock_c(rd_stock_c),
        .i_wr_en     (wr_en_c),
        .i_wr_idx    (wr_idx_c),
        .i_wr_valid  (wr_valid_c),
        .i_wr_name   (wr_name_c),
        .i_wr_stock  (wr_stock_c)
    );

    assign match_c = rd_valid_c && (rd_name_c == lat_name);

    // Result and table write for the UPDATE cycle, from the scan outcome.
    always_comb begin
        wr_en_c     = 1'b0;
        wr_idx_c    = hit_idx;
        wr_valid_c  = 1'b1;
        wr_name_c   = lat_name;
        wr_stock_c  = hit_stock;
        upd_code_c  = RSP_NOT_FOUND;
        upd_stock_c = '0;
        sat_sum_c   = {1'b0, hit_stock} + {1'b0, lat_qty};
        case (lat_op)
            OP_ADD: begin
                if (found) begin
                    upd_code_c  = RSP_OK;
                    upd_stock_c = sat_sum_c[STOCK_BITS] ? '1 : sat_sum_c[STOCK_BITS-1:0];
                    wr_en_c     = 1'b1;
                    wr_stock_c  = upd_stock_c;
                end else if (free_found) begin
                    upd_code_c  = RSP_OK;
                    upd_stock_c = lat_qty;
                    wr_en_c     = 1'b1;
                    wr_idx_c    = free_idx;
                    wr_stock_c  = lat_qty;
                end else begin
                    upd_code_c  = RSP_TBL_FULL;
                end
            end
            OP_DEL: begin
                if (found) begin
                    upd_code_c = RSP_OK;
                    wr_en_c    = 1'b1;
                    wr_valid_c = 1'b0;
                    wr_name_c  = '0;
                    wr_stock_c = '0;
                end
            end
            OP_BUY: begin
                if (found) begin
                    if (hit_stock >= lat_qty) begin
                        upd_code_c  = RSP_OK;
                        upd_stock_c = hit_stock - lat_qty;
                        wr_en_c     = 1'b1;
                        wr_stock_c  = upd_stock_c;
                    end else begin
                        upd_code_c  = RSP_NO_STOCK;
                        upd_stock_c = hit_stock;
                    end
                end
            end
            default: begin
                if (found) begin
                    upd_code_c  = RSP_OK;
                    upd_stock_c = hit_stock;
                end
            end
        endcase
        if (state != ST_UPDATE) begin
            wr_en_c = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state       <= ST_IDLE;
            lat_op      <= OP_ADD;
            lat_name    <= '0;
            lat_qty     <= '0;
            scan_idx    <= '0;
            found       <= 1'b0;
            hit_idx     <= '0;
            hit_stock   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            o_req_ready <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_code  <= '0;
            o_rsp_stock <= '0;
            o_busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req_valid && o_req_ready) begin
                        lat_op      <= op_e'(i_req_op);
                        lat_name    <= i_req_name;
                        lat_qty     <= i_req_qty;
                        scan_idx    <= '0;
                        found       <= 1'b0;
                        hit_idx     <= '0;
                        hit_stock   <= '0;
                        free_found  <= 1'b0;
                        free_idx    <= '0;
                        o_req_ready <= 1'b0;
                        o_busy      <= 1'b1;
                        // Table mutation is admin-only; refuse without scanning.
                        if ((op_e'(i_req_op) == OP_ADD || op_e'(i_req_op) == OP_DEL)
                            && !i_req_is_admin) begin
                            state       <= ST_RESP;
                            o_rsp_valid <= 1'b1;
                            o_rsp_code  <= RSP_NO_PERM;
                            o_rsp_stock <= '0;
                        end else begin
                            state <= ST_SCAN;
                        end
                    end else begin
                        o_req_ready <= 1'b1;
                        o_busy      <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (!rd_valid_c && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    if (match_c) begin
                        found     <= 1'b1;
                        hit_idx   <= scan_idx;
                        hit_stock <= rd_stock_c;
                        state     <= ST_UPDATE;
                    end else if (scan_idx == LAST_IDX) begin
                        state <= ST_UPDATE;
                    end else begin
                        scan_idx <= scan_idx + IDX_BITS'(1);
                    end
                end
                ST_UPDATE: begin
                    state       <= ST_RESP;
                    o_rsp_valid <= 1'b1;
                    o_rsp_code  <= upd_code_c;
                    o_rsp_stock <= upd_stock_c;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        state       <= ST_IDLE;
                        o_rsp_valid <= 1'b0;
                        o_req_ready <= 1'b1;
                        o_busy      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_item_db_ctrl.sv
// Directed self-checking bench for item_db_ctrl.
module tb_item_db_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [23:0] req_name;
    logic [7:0]  req_qty;
    logic        req_admin;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_code;
    logic [7:0]  rsp_stock;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] ADD = 2'd0, DEL = 2'd1, BUY = 2'd2, QRY = 2'd3;
    localparam logic [23:0] PEN = "Pen";
    localparam logic [23:0] INK = "Ink";

    item_db_ctrl dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_op      (req_op),
        .i_req_name    (req_name),
        .i_req_qty     (req_qty),
        .i_req_is_admin(req_admin),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_code    (rsp_code),
        .o_rsp_stock   (rsp_stock),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request from a negedge; returns response fields and cycles from accept.
    task automatic do_req(input logic [1:0] op, input logic [23:0] nm, input logic [7:0] qty,
                          input logic adm, input bit ack,
                          output logic [2:0] code, output logic [7:0] stock, output int lat);
        int guard;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            n_checks++; n_fail++;
            $display("FAIL req_ready_timeout got=0 exp=1");
        end
        req_valid = 1'b1; req_op = op; req_name = nm; req_qty = qty; req_admin = adm;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_valid_timeout got=0 exp=1");
        end
        code  = rsp_code;
        stock = rsp_stock;
        if (ack) begin
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 2'd0; req_name = '0; req_qty = '0; req_admin = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rsp_valid, busy, req_ready} !== 3'b000) begin n_fail++;
            $display("FAIL reset_ctrl got=%b exp=000", {rsp_valid, busy, req_ready}); end
        n_checks++;
        if ({rsp_code, rsp_stock} !== 11'd0) begin n_fail++;
            $display("FAIL reset_rsp got=%0d/%0d exp=0/0", rsp_code, rsp_stock); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++;
            $display("FAIL idle_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_add_new();
        logic [2:0] c; logic [7:0] s; int l;
        do_req(ADD, PEN, 8'd5, 1'b1, 1'b1, c, s, l);
        n_checks++;
        if ({c, s} !== {3'd0, 8'd5}) begin n_fail++;
            $display("FAIL add_pen got=%0d/%0d exp=0/5", c, s); end
        n_checks++;
        if (l !== 10) begin n_fail++; $display("FAIL add_pen_latency got=%0d exp=10", l); end
        do_req(QRY, PEN, 8'd0, 1'b0, 1'b1, c, s, l);
        n_checks++;
        if ({c, s, 8'(l)} !== {3'd0, 8'd5, 8'd3}) begin n_fail++;
            $display("FAIL query_pen_idx0 got=%0d/%0d/%0d exp=0/5/3", c, s, l); end
    endtask

    task automatic test_no_perm();
        logic [2:0] c; logic [7:0] s; int l;
        do_req(ADD, INK, 8'd3, 1'b0, 1'b1, c, s, l);
        n_checks++;
        if ({c, s, 8'(l)} !== {3'd4, 8'd0, 8'd1}) begin n_fail++;
            $display("FAIL no_perm_add got=%0d/%0d/%0d exp=4/0/1", c, s, l); end
        do_req(DEL, PEN, 8'd0, 1'b0, 1'b1, c, s, l);
        n_checks++;
        if ({c, s, 8'(l)} !== {3'd4, 8'd0, 8'd1}) begin n_fail++;
            $display("FAIL no_perm_del got=%0d/%0d/%0d exp=4/0/1", c, s, l); end
        do_req(QRY, INK, 8'd0, 1'b0, 1'b1, c, s, l);
        n_checks++;
        if ({c, s, 8'(l)} !== {3'd1, 8'd0, 8'd10}) begin n_fail++;
            $display("FAIL query_ink_absent got=%0d/%0d/%0d exp=1/0/10", c, s, l); end
    endtask

    task automatic test_buy();
        logic [2:0] c; logic [7:0] s; int l;
        logic [7:0]  qty [3] = '{8'd2, 8'd4, 8'd0};
        logic [2:0]  ec  [3] = '{3'd0, 3'd2, 3'd0};
        for (int i = 0; i < 3; i++) begin
            do_req(BUY, PEN, qty[i], 1'b0, 1'b1, c, s, l);
            n_checks++;
            if ({c, s} !== {ec[i], 8'd3}) begin n_fail++;
                $display("FAIL buy_%0d got=%0d/%0d exp=%0d/3", i, c, s, ec[i]); end
        end
    endtask

    task automatic test_saturate();
        logic [2:0] c; logic [7:0] s; int l;
        do_req(ADD, PEN, 8'd7, 1'b1, 1'b1, c, s, l);
        n_checks++;
        if ({c, s} !== {3'd0, 8'd10}) begin n_fail++;
            $display("FAIL add_to_10 got=%0d/%0d exp=0/10", c, s); end
        do_req(ADD, PEN, 8'd250, 1'b1, 1'b1, c, s, l);
        n_checks++;
        if ({c, s} !== {3'd0, 8'd255}) begin n_fail++;
            $display("FAIL add_saturate got=%0d/%0d exp=0/255", c, s); end
    endtask

    task automatic test_table_full();
        logic [2:0] c; logic [7:0] s; int l;
        int bad;
        bad = 0;
        // Slot 0 holds Pen; items "It1".."It7" land in slots 1..7.
        for (int i = 1; i < 8; i++) begin
            do_req(ADD, {"It", 8'(8'h30 + i)}, 8'(i), 1'b1, 1'b1, c, s, l);
            if ({c, s} !== {3'd0, 8'(i)}) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL fill_table got=%0d_bad exp=0_bad", bad); end
        do_req(ADD, "It9", 8'd9, 1'b1, 1'b1, c, s, l);
        n_checks++;
        if ({c, s} !== {3'd3, 8'd0}) begin n_fail++;
            $display("FAIL tbl_full got=%0d/%0d exp=3/0", c, s); end
        do_req(DEL, "It2", 8'd0, 1'b1, 1'b1, c, s, l);
        n_checks++;
        if ({c, s, 8'(l)} !== {3'd0, 8'd0, 8'd5}) begin n_fail++;
            $display("FAIL del_idx2 got=%0d/%0d/%0d exp=0/0/5", c, s, l); end
        do_req(ADD, "It9", 8'd9, 1'b1, 1'b1, c, s, l);
        n_checks++;
        if ({c, s} !== {3'd0, 8'd9}) begin n_fail++;
            $display("FAIL reuse_slot got=%0d/%0d exp=0/9", c, s); end
        do_req(QRY, "It9", 8'd0, 1'b0, 1'b1, c, s, l);
        n_checks++;
        if ({c, s, 8'(l)} !== {3'd0, 8'd9, 8'd5}) begin n_fail++;
            $display("FAIL reuse_at_idx2 got=%0d/%0d/%0d exp=0/9/5", c, s, l); end
    endtask

    task automatic test_hold_and_reset();
        logic [2:0] c; logic [7:0] s; int l;
        int bad;
        do_req(QRY, PEN, 8'd0, 1'b0, 1'b0, c, s, l);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if ({rsp_valid, rsp_code, rsp_stock, req_ready, busy} !== {1'b1, 3'd0, 8'd255, 1'b0, 1'b1})
                bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL rsp_hold got=%0d_bad exp=0_bad", bad); end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin n_fail++;
            $display("FAIL rsp_release got=%b exp=01", {rsp_valid, req_ready}); end
        // Abort an ADD while it is still scanning.
        req_valid = 1'b1; req_op = ADD; req_name = "Zed"; req_qty = 8'd1; req_admin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, busy, req_ready} !== 3'b000) begin n_fail++;
            $display("FAIL midscan_reset got=%b exp=000", {rsp_valid, busy, req_ready}); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({req_ready, busy} !== 2'b10) begin n_fail++;
            $display("FAIL idle_after_reset got=%b exp=10", {req_ready, busy}); end
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL dropped_rsp got=%0d exp=0", bad); end
        do_req(QRY, PEN, 8'd0, 1'b0, 1'b1, c, s, l);
        n_checks++;
        if ({c, s} !== {3'd1, 8'd0}) begin n_fail++;
            $display("FAIL table_cleared got=%0d/%0d exp=1/0", c, s); end
    endtask

    initial begin
        test_reset();
        test_add_new();
        test_no_perm();
        test_buy();
        test_saturate();
        test_table_full();
        test_hold_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
